world_clock_ctrl: RTL

WORLD_CLOCK_CTRL -- requirements
Module: world_clock_ctrl

---
 rtl/world_clock_pkg.sv | 78 +++++++
 rtl/btn_sync_edge.sv | 44 ++++
 rtl/world_clock_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/world_clock_pkg.sv
// Shared types and constants for the world-clock front-panel controller:
// mode encoding, increment-pulse bit positions and per-mode blink patterns.
package world_clock_pkg;

    typedef enum logic [2:0] {
        SHOW_TIME = 3'd0,
        SHOW_DATE = 3'd1,
        SET_HOUR  = 3'd2,
        SET_MIN   = 3'd3,
        SET_DAY   = 3'd4,
        SET_MONTH = 3'd5,
        SET_YEAR  = 3'd6
    } mode_e;

    localparam int INC_HOUR  = 4;
    localparam int INC_MIN   = 3;
    localparam int INC_DAY   = 2;
    localparam int INC_MONTH = 1;
    localparam int INC_YEAR  = 0;

    // bit3 = ss7/6 ... bit0 = ss1/0
    localparam logic [3:0] BLINK_HOUR  = 4'b1010;
    localparam logic [3:0] BLINK_MIN   = 4'b0101;
    localparam logic [3:0] BLINK_DAY   = 4'b1000;
    localparam logic [3:0] BLINK_MONTH = 4'b0100;
    localparam logic [3:0] BLINK_YEAR  = 4'b0011;

    function automatic logic is_set_mode(input mode_e m);
        return (m == SET_HOUR) || (m == SET_MIN) || (m == SET_DAY) ||
               (m == SET_MONTH) || (m == SET_YEAR);
    endfunction

    function automatic mode_e next_mode(input mode_e m);
        mode_e n;
        case (m)
            SHOW_TIME: n = SET_HOUR;
            SHOW_DATE: n = SET_HOUR;
            SET_HOUR:  n = SET_MIN;
            SET_MIN:   n = SET_DAY;
            SET_DAY:   n = SET_MONTH;
            SET_MONTH: n = SET_YEAR;
            default:   n = SHOW_TIME;
        endcase
        return n;
    endfunction

    function automatic logic [4:0] inc_of(input mode_e m);
        logic [4:0] v;
        v = '0;
        case (m)
            SET_HOUR:  v[INC_HOUR]  = 1'b1;
            SET_MIN:   v[INC_MIN]   = 1'b1;
            SET_DAY:   v[INC_DAY]   = 1'b1;
            SET_MONTH: v[INC_MONTH] = 1'b1;
            SET_YEAR:  v[INC_YEAR]  = 1'b1;
            default:   v = '0;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] blink_of(input mode_e m);
        logic [3:0] v;
        case (m)
            SET_HOUR:  v = BLINK_HOUR;
            SET_MIN:   v = BLINK_MIN;
            SET_DAY:   v = BLINK_DAY;
            SET_MONTH: v = BLINK_MONTH;
            SET_YEAR:  v = BLINK_YEAR;
            default:   v = '0;
        endcase
        return v;
    endfunction

    function automatic logic disp_of(input mode_e m);
        return (m == SHOW_DATE) || (m == SET_DAY) || (m == SET_MONTH) || (m == SET_YEAR);
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer plus registered rising-edge detector for one push button.
// A press sampled at cycle N gives edge_o at cycle N+2.
module btn_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_i,
    output logic level_o,
    output logic edge_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic edge_q;
    logic prime1_q;
    logic prime2_q;
    logic armed_q;

    // armed_q only sets once the synchronizer holds a real sample and has seen
    // the button released, so a button held through reset stays silent.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            edge_q   <= 1'b0;
            prime1_q <= 1'b0;
            prime2_q <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            edge_q   <= sync2_q & ~prev_q & armed_q;
            prime1_q <= 1'b1;
            prime2_q <= prime1_q;
            armed_q  <= armed_q | (prime2_q & ~sync2_q);
        end
    end

    assign level_o = sync2_q & armed_q;
    assign edge_o  = edge_q;

endmodule

// File: rtl/world_clock_ctrl.sv
// Front-panel mode controller for a world clock: mode/page/up buttons, set-mode
// timeout, auto-repeat increment and digit blinking.
//   state     | meaning
//   SHOW_TIME | time view, buttons page/mode active
//   SHOW_DATE | date view, buttons page/mode active
//   SET_HOUR  | editing hours (time view)
//   SET_MIN   | editing minutes (time view)
//   SET_DAY   | editing day (date view)
//   SET_MONTH | editing month (date view)
//   SET_YEAR  | editing year (date view)
module world_clock_ctrl
    import world_clock_pkg::*;
#(
    parameter int TIMEOUT_S  = 10,
    parameter int REPEAT_DLY = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_page,
    input  logic       btn_up,
    output logic [2:0] mode,
    output logic       disp_sel,
    output logic [4:0] inc,
    output logic [3:0] blink_mask,
    output logic       setting
);

    localparam int TW = $clog2(TIMEOUT_S + 1);
    localparam int RW = $clog2(REPEAT_DLY + 1);

    logic mode_edge, page_edge, up_edge;
    logic mode_level, page_level, up_level;
    logic unused_levels;

    btn_sync_edge u_sync_mode (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_i   (btn_mode),
        .level_o (mode_level),
        .edge_o  (mode_edge)
    );

    btn_sync_edge u_sync_page (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_i   (btn_page),
        .level_o (page_level),
        .edge_o  (page_edge)
    );

    btn_sync_edge u_sync_up (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_i   (btn_up),
        .level_o (up_level),
        .edge_o  (up_edge)
    );

    assign unused_levels = mode_level | page_level;

    mode_e         state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [RW-1:0] rep_q, rep_d;
    logic          phase_q, phase_d;
    logic [4:0]    inc_q, inc_d;
    logic          disp_q;
    logic          set_q;
    logic [3:0]    blink_q;

    logic any_edge;
    logic in_set;
    logic rep_active;
    logic rep_fire;
    logic timeout_hit;

    assign any_edge    = mode_edge | page_edge | up_edge;
    assign in_set      = is_set_mode(state_q);
    assign rep_active  = up_level & in_set;
    assign rep_fire    = rep_active & tick_1hz & (int'(rep_q) >= REPEAT_DLY - 1);
    // Any button activity restarts the idle window, so it also blocks a timeout.
    assign timeout_hit = ~any_edge & in_set & tick_1hz & (int'(tmo_q) >= TIMEOUT_S - 1);

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        rep_d   = rep_q;
        phase_d = phase_q;
        inc_d   = '0;

        if (mode_edge) begin
            state_d = next_mode(state_q);
        end else if (page_edge && state_q == SHOW_TIME) begin
            state_d = SHOW_DATE;
        end else if (page_edge && state_q == SHOW_DATE) begin
            state_d = SHOW_TIME;
        end else if (timeout_hit) begin
            state_d = SHOW_TIME;
        end

        if (!mode_edge && !timeout_hit && in_set && (up_edge || rep_fire)) begin
            inc_d = inc_of(state_q);
        end

        if (!rep_active) begin
            rep_d = '0;
        end else if (tick_1hz && int'(rep_q) < REPEAT_DLY) begin
            rep_d = rep_q + RW'(1);
        end

        if (any_edge || state_d != state_q) begin
            tmo_d = '0;
        end else if (tick_1hz && in_set && int'(tmo_q) < TIMEOUT_S) begin
            tmo_d = tmo_q + TW'(1);
        end

        if (any_edge) begin
            phase_d = 1'b0;
        end else if (tick_1hz) begin
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SHOW_TIME;
            tmo_q   <= '0;
            rep_q   <= '0;
            phase_q <= 1'b0;
            inc_q   <= '0;
            disp_q  <= 1'b0;
            set_q   <= 1'b0;
            blink_q <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            rep_q   <= rep_d;
            phase_q <= phase_d;
            inc_q   <= inc_d;
            disp_q  <= disp_of(state_d);
            set_q   <= is_set_mode(state_d);
            blink_q <= (phase_d && is_set_mode(state_d)) ? blink_of(state_d) : 4'b0000;
        end
    end

    assign mode       = state_q;
    assign disp_sel   = disp_q;
    assign inc        = inc_q;
    assign blink_mask = blink_q;
    assign setting    = set_q;

endmodule
